// File: rtl/onehot_enc8x3_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_pkg
// Description : Shared widths, result struct and one-hot check helper for
//               the onehot_enc8x3_pipe encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

    localparam int ENC_IN_W   = 8;
    localparam int ENC_CODE_W = 3;

    typedef struct packed {
        logic [ENC_CODE_W-1:0] code;
        logic                  err;
        logic                  zero;
    } enc_res_t;

    typedef struct packed {
        logic zero;
        logic multi;
    } enc_chk_t;

    function automatic enc_chk_t onehot_check(input logic [ENC_IN_W-1:0] d);
        enc_chk_t r;
        r.zero  = (d == '0);
        r.multi = ($countones(d) > 1);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_enc8x3_pipe_prio.sv
`default_nettype none
// ============================================================================
// Module      : onehot_prio_enc8
// Description : Combinational highest-set-bit encoder, 8 inputs to 3-bit code.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_prio_enc8
    import enc_pkg::*;
(
    input  logic [ENC_IN_W-1:0]   data_i,
    output logic [ENC_CODE_W-1:0] code_o
);

    // Ascending scan so the last hit, i.e. the highest bit, wins.
    always_comb begin
        code_o = '0;
        for (int i = 0; i < ENC_IN_W; i++) begin
            if (data_i[i]) begin
                code_o = i[ENC_CODE_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/onehot_enc8x3_pipe.sv
`default_nettype none
// ============================================================================
// Module      : onehot_enc8x3_pipe
// Description : Two-stage valid/ready 8-to-3 one-hot encoder with error flags.
//               Define ENC_ERR_CNT_EN to build the saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_enc8x3_pipe
    import enc_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ENC_IN_W-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ENC_CODE_W-1:0] out_code,
    output logic                  out_err,
    output logic                  out_zero,
    input  logic                  err_clr,
    output logic [ERR_CNT_W-1:0]  err_count
);

    logic                  s1_valid_q;
    logic [ENC_IN_W-1:0]   s1_data_q;
    enc_chk_t              s1_chk_q;
    logic                  s2_valid_q;
    enc_res_t              s2_res_q;
    enc_res_t              s2_res_d;
    enc_chk_t              w_chk;
    logic [ENC_CODE_W-1:0] w_code;
    logic                  w_s1_adv;
    logic                  w_s2_adv;

    assign w_chk    = onehot_check(in_data);
    assign w_s2_adv = !s2_valid_q || out_ready;
    assign w_s1_adv = !s1_valid_q || w_s2_adv;
    assign in_ready = w_s1_adv;

    onehot_prio_enc8 u_prio (
        .data_i (s1_data_q),
        .code_o (w_code)
    );

    always_comb begin
        s2_res_d      = s2_res_q;
        if (w_s2_adv && s1_valid_q) begin
            s2_res_d.code = w_code;
            s2_res_d.err  = s1_chk_q.zero || s1_chk_q.multi;
            s2_res_d.zero = s1_chk_q.zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_chk_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
        end else begin
            if (w_s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_data_q <= in_data;
                    s1_chk_q  <= w_chk;
                end
            end
            if (w_s2_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            s2_res_q <= s2_res_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_code  = s2_res_q.code;
    assign out_err   = s2_res_q.err;
    assign out_zero  = s2_res_q.zero;

`ifdef ENC_ERR_CNT_EN
    localparam logic [ERR_CNT_W-1:0] C_CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Clear has priority over a same-cycle increment; count saturates.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_cnt_q <= '0;
        end else if (out_valid && out_ready && s2_res_q.err && !(&err_cnt_q)) begin
            err_cnt_q <= err_cnt_q + C_CNT_ONE;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign err_count        = '0;
`endif

endmodule
`default_nettype wire
